// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control FSM with memory-ready wait states, a memory
// timeout, full branch-condition decode, LUI, two-step JALR, a sticky trap
// on illegal encodings, and an integrated ALU control decoder.
//
// Handshake: in FETCH, MEM_READ and MEM_WRITE the controller holds mem_req
// (and the address/write selects) steady until the cycle in which
// mem_ready=1; that cycle completes the access. No access is issued in any
// other state.
module mc_controller_hs #(
  parameter int MEM_TIMEOUT    = 16,
  parameter bit BR_UNSIGNED_EN = 1'b1,
  parameter int STATE_W        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               zero,
  input  logic               negative,
  input  logic               overflow,
  input  logic               carry,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               pc_write,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrca,
  output logic [1:0]         ALUSrcb,
  output logic [3:0]         ALUControl,
  output logic               trap,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_JAL       = 4'd9,
    S_JALR_A    = 4'd10,
    S_JALR_PC   = 4'd11,
    S_BRANCH    = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // The counter holds 0..MEM_TIMEOUT; with the timeout disabled a 1-bit
  // counter is kept that stays at zero.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_t           ps, ns;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_access, waiting, timeout;
  logic             mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign f7b5        = instruction[30];
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // A wait cycle is any memory-state cycle whose access does not complete.
  assign mem_access = (ps == S_FETCH) || (ps == S_MEM_READ) || (ps == S_MEM_WRITE);
  assign waiting    = mem_access && !mem_ready;
  // Fires on the wait cycle that brings the counter to MEM_TIMEOUT.
  assign timeout    = TIMEOUT_EN && waiting && (wait_cnt == CNT_LAST);

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    logic [3:0] r;
    case (f3)
      3'b000:  r = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Present-state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps <= S_FETCH;
    else       ps <= ns;
  end

  // Wait counter: clears whenever the state changes (so on every entry to a
  // memory state) and counts cycles spent waiting on mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wait_cnt <= '0;
    else if (ns != ps)              wait_cnt <= '0;
    else if (TIMEOUT_EN && waiting) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state and datapath control decode.
  always_comb begin
    ns          = ps;
    mem_req_c   = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrca     = 2'b00;
    ALUSrcb     = 2'b00;
    ALUControl  = ALU_ADD;
    trap        = 1'b0;
    case (ps)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcb   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          ns         = S_DECODE;
        end else if (timeout) begin
          ns = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrca = 2'b01;
        ALUSrcb = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: ns = S_MEM_ADDR;
          OP_R:              ns = S_EXEC_R;
          OP_I:              ns = S_EXEC_I;
          OP_JAL:            ns = S_JAL;
          OP_JALR:           ns = S_JALR_A;
          OP_BRANCH:         ns = S_BRANCH;
          OP_AUIPC:          ns = S_ALU_WB;
          OP_LUI:            ns = S_LUI;
          default:           ns = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrca = 2'b10;
        ALUSrcb = 2'b01;
        ns      = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready)    ns = S_MEM_WB;
        else if (timeout) ns = S_TRAP;
      end
      S_MEM_WB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        ns          = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        AdrSrc      = 1'b1;
        if (mem_ready)    ns = S_FETCH;
        else if (timeout) ns = S_TRAP;
      end
      S_EXEC_R: begin
        ALUSrca    = 2'b10;
        ALUControl = alu_dec(funct3, f7b5, 1'b1);
        ns         = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrca    = 2'b10;
        ALUSrcb    = 2'b01;
        ALUControl = alu_dec(funct3, f7b5, 1'b0);
        ns         = S_ALU_WB;
      end
      S_LUI: begin
        ALUSrca = 2'b11;
        ALUSrcb = 2'b01;
        ns      = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        ns          = S_FETCH;
      end
      S_JAL, S_JALR_PC: begin
        // PC takes the target held in ALUOut while the ALU forms the link.
        pc_write_c = 1'b1;
        ALUSrca    = 2'b01;
        ALUSrcb    = 2'b10;
        ns         = S_ALU_WB;
      end
      S_JALR_A: begin
        ALUSrca = 2'b10;
        ALUSrcb = 2'b01;
        ns      = S_JALR_PC;
      end
      S_BRANCH: begin
        ALUSrca    = 2'b10;
        ALUControl = ALU_SUB;
        ns         = S_FETCH;
        case (funct3)
          3'b000: pc_write_c = zero;
          3'b001: pc_write_c = !zero;
          3'b100: pc_write_c = negative ^ overflow;
          3'b101: pc_write_c = !(negative ^ overflow);
          3'b110: if (BR_UNSIGNED_EN) pc_write_c = !carry; else ns = S_TRAP;
          3'b111: if (BR_UNSIGNED_EN) pc_write_c = carry;  else ns = S_TRAP;
          default: ns = S_TRAP;
        endcase
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: ns = S_TRAP;
    endcase
  end

  // Strobes are held off while reset is asserted so an abandoned access
  // cannot write anything.
  assign mem_req  = mem_req_c   && !reset;
  assign MemWrite = mem_write_c && !reset;
  assign IRWrite  = ir_write_c  && !reset;
  assign pc_write = pc_write_c  && !reset;
  assign RegWrite = reg_write_c && !reset;
  assign state    = STATE_W'(ps);

endmodule

// File: tb/tb_mc_controller_hs.sv
// Bench for mc_controller_hs. Two instances: u_dut with default parameters
// and u_dut2 with MEM_TIMEOUT=4, BR_UNSIGNED_EN=0. Each stimulus cycle
// pushes the expected control vector; the monitor compares on the falling
// edge.
module tb_mc_controller_hs;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst2, mem_ready, mem_ready2;
  logic [31:0] instruction;
  logic        zero, negative, overflow, carry;

  logic       mreq1, adr1, mw1, irw1, pcw1, rw1, trap1;
  logic [1:0] rs1, sa1, sb1;
  logic [3:0] alu1, st1;
  logic       mreq2, adr2, mw2, irw2, pcw2, rw2, trap2;
  logic [1:0] rs2, sa2, sb2;
  logic [3:0] alu2, st2;

  mc_controller_hs u_dut (
    .clk(clk), .reset(rst1), .instruction(instruction),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .mem_ready(mem_ready), .mem_req(mreq1), .AdrSrc(adr1), .MemWrite(mw1),
    .IRWrite(irw1), .pc_write(pcw1), .RegWrite(rw1), .ResultSrc(rs1),
    .ALUSrca(sa1), .ALUSrcb(sb1), .ALUControl(alu1), .trap(trap1), .state(st1)
  );

  mc_controller_hs #(.MEM_TIMEOUT(4), .BR_UNSIGNED_EN(1'b0), .STATE_W(4)) u_dut2 (
    .clk(clk), .reset(rst2), .instruction(instruction),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .mem_ready(mem_ready2), .mem_req(mreq2), .AdrSrc(adr2), .MemWrite(mw2),
    .IRWrite(irw2), .pc_write(pcw2), .RegWrite(rw2), .ResultSrc(rs2),
    .ALUSrca(sa2), .ALUSrcb(sb2), .ALUControl(alu2), .trap(trap2), .state(st2)
  );

  // Vector layout: {state, mem_req, AdrSrc, MemWrite, IRWrite, pc_write,
  // RegWrite, ResultSrc, ALUSrca, ALUSrcb, ALUControl, trap}
  logic [20:0] vec1, vec2;
  assign vec1 = {st1, mreq1, adr1, mw1, irw1, pcw1, rw1, rs1, sa1, sb1, alu1, trap1};
  assign vec2 = {st2, mreq2, adr2, mw2, irw2, pcw2, rw2, rs2, sa2, sb2, alu2, trap2};

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001;

  function automatic logic [20:0] ev(input logic [3:0] st, input logic [5:0] strb,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [3:0] alu,
                                     input logic trp);
    return {st, strb, rs, a, b, alu, trp};
  endfunction

  function automatic logic [20:0] f_fetch(input logic r);
    return ev(4'd0, {1'b1, 1'b0, 1'b0, r, r, 1'b0}, 2'b10, 2'b00, 2'b10, ADD, 1'b0);
  endfunction
  function automatic logic [20:0] f_decode();
    return ev(4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, ADD, 1'b0);
  endfunction
  function automatic logic [20:0] f_alu_wb();
    return ev(4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, ADD, 1'b0);
  endfunction
  function automatic logic [20:0] f_trap();
    return ev(4'd14, 6'b000000, 2'b00, 2'b00, 2'b00, ADD, 1'b1);
  endfunction
  function automatic logic [20:0] f_rst();
    return ev(4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, ADD, 1'b0);
  endfunction

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [21:0] ent;
  logic [20:0] act;
  string       nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = ent[21] ? vec2 : vec1;
      checks++;
      if (act !== ent[20:0]) begin
        failures++;
        $display("FAIL %s: dut%0d state=%0d vec=%h, expected state=%0d vec=%h",
                 nm, ent[21] ? 2 : 1, act[20:17], act, ent[20:17], ent[20:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic sel, input logic rdy, input logic [20:0] e,
                      input string n);
    if (sel) mem_ready2 = rdy;
    else     mem_ready  = rdy;
    exp_q.push_back({sel, e});
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst1 = 1'b1;
    rst2 = 1'b1;
    step(1'b0, 1'b0, f_rst(), "reset1");
    step(1'b1, 1'b0, f_rst(), "reset2");
    rst1 = 1'b0;
    rst2 = 1'b0;
  endtask

  task automatic set_flags(input logic z, input logic n, input logic v, input logic c);
    zero = z; negative = n; overflow = v; carry = c;
  endtask

  // ALU-op table: instruction, R-type?, expected ALUControl
  logic [31:0] t_ins [0:10] = '{32'h402081B3, 32'h0020F1B3, 32'h0020B1B3, 32'h4020D1B3,
                                32'h4020D193, 32'hC0000093, 32'h0FF0C193, 32'h00209193,
                                32'h0020D193, 32'h0010E193, 32'h0010A193};
  logic        t_r   [0:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0};
  logic [3:0]  t_alu [0:10] = '{4'b0001, 4'b0010, 4'b0110, 4'b1001, 4'b1001, 4'b0000,
                                4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b0101};

  // Branch table: funct3, {zero,negative,overflow,carry}, expected pc_write
  logic [2:0] b_f3  [0:8] = '{3'b000, 3'b001, 3'b100, 3'b100, 3'b101, 3'b101,
                              3'b110, 3'b111, 3'b111};
  logic [3:0] b_fl  [0:8] = '{4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b0100, 4'b0000,
                              4'b0000, 4'b0000, 4'b0001};
  logic       b_pcw [0:8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    rst1 = 1'b1; rst2 = 1'b1; mem_ready = 1'b0; mem_ready2 = 1'b0;
    instruction = 32'h0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // addi x1,x0,5 : 0,1,7,8
    instruction = 32'h00500093;
    step(1'b0, 1'b1, f_fetch(1'b1), "addi_fetch");
    step(1'b0, 1'b0, f_decode(), "addi_decode");
    step(1'b0, 1'b0, ev(4'd7, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "addi_exec");
    step(1'b0, 1'b0, f_alu_wb(), "addi_wb");

    // lw with three wait cycles in MEM_READ
    instruction = 32'h0000A103;
    step(1'b0, 1'b1, f_fetch(1'b1), "lw_fetch");
    step(1'b0, 1'b0, f_decode(), "lw_decode");
    step(1'b0, 1'b0, ev(4'd2, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "lw_addr");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, ev(4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, ADD, 1'b0), "lw_wait");
    step(1'b0, 1'b1, ev(4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, ADD, 1'b0), "lw_read");
    step(1'b0, 1'b0, ev(4'd4, 6'b000001, 2'b01, 2'b00, 2'b00, ADD, 1'b0), "lw_wb");

    // R/I ALU decode
    for (int i = 0; i <= 10; i++) begin
      instruction = t_ins[i];
      step(1'b0, 1'b1, f_fetch(1'b1), "alu_fetch");
      step(1'b0, 1'b0, f_decode(), "alu_decode");
      step(1'b0, 1'b0, ev(t_r[i] ? 4'd6 : 4'd7, 6'b0, 2'b00, 2'b10,
                          t_r[i] ? 2'b00 : 2'b01, t_alu[i], 1'b0), "alu_exec");
      step(1'b0, 1'b0, f_alu_wb(), "alu_wb");
    end

    // branch conditions
    for (int i = 0; i <= 8; i++) begin
      instruction = 32'h00208463 | {17'b0, b_f3[i], 12'b0};
      set_flags(b_fl[i][3], b_fl[i][2], b_fl[i][1], b_fl[i][0]);
      step(1'b0, 1'b1, f_fetch(1'b1), "br_fetch");
      step(1'b0, 1'b0, f_decode(), "br_decode");
      step(1'b0, 1'b0, ev(4'd12, {4'b0, b_pcw[i], 1'b0}, 2'b00, 2'b10, 2'b00, SUB, 1'b0),
           "br_exec");
    end
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);

    // jal, jalr, lui, auipc
    instruction = 32'h008000EF;
    step(1'b0, 1'b1, f_fetch(1'b1), "jal_fetch");
    step(1'b0, 1'b0, f_decode(), "jal_decode");
    step(1'b0, 1'b0, ev(4'd9, 6'b000010, 2'b00, 2'b01, 2'b10, ADD, 1'b0), "jal_pc");
    step(1'b0, 1'b0, f_alu_wb(), "jal_wb");
    instruction = 32'h000100E7;
    step(1'b0, 1'b1, f_fetch(1'b1), "jalr_fetch");
    step(1'b0, 1'b0, f_decode(), "jalr_decode");
    step(1'b0, 1'b0, ev(4'd10, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "jalr_a");
    step(1'b0, 1'b0, ev(4'd11, 6'b000010, 2'b00, 2'b01, 2'b10, ADD, 1'b0), "jalr_pc");
    step(1'b0, 1'b0, f_alu_wb(), "jalr_wb");
    instruction = 32'h123452B7;
    step(1'b0, 1'b1, f_fetch(1'b1), "lui_fetch");
    step(1'b0, 1'b0, f_decode(), "lui_decode");
    step(1'b0, 1'b0, ev(4'd13, 6'b0, 2'b00, 2'b11, 2'b01, ADD, 1'b0), "lui_exec");
    step(1'b0, 1'b0, f_alu_wb(), "lui_wb");
    instruction = 32'h00001097;
    step(1'b0, 1'b1, f_fetch(1'b1), "auipc_fetch");
    step(1'b0, 1'b0, f_decode(), "auipc_decode");
    step(1'b0, 1'b0, f_alu_wb(), "auipc_wb");

    // sw with one wait cycle, completes normally
    instruction = 32'h0020A223;
    step(1'b0, 1'b1, f_fetch(1'b1), "sw_fetch");
    step(1'b0, 1'b0, f_decode(), "sw_decode");
    step(1'b0, 1'b0, ev(4'd2, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "sw_addr");
    step(1'b0, 1'b0, ev(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, ADD, 1'b0), "sw_wait");
    step(1'b0, 1'b1, ev(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, ADD, 1'b0), "sw_write");

    // sw abandoned by reset mid-access
    step(1'b0, 1'b1, f_fetch(1'b1), "sw2_fetch");
    step(1'b0, 1'b0, f_decode(), "sw2_decode");
    step(1'b0, 1'b0, ev(4'd2, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "sw2_addr");
    step(1'b0, 1'b0, ev(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, ADD, 1'b0), "sw2_wait");
    rst1 = 1'b1;
    step(1'b0, 1'b0, f_rst(), "sw2_reset");
    rst1 = 1'b0;
    step(1'b0, 1'b0, f_fetch(1'b0), "sw2_after");

    // illegal branch funct3 and illegal opcode
    do_reset();
    instruction = 32'h0020A463;
    step(1'b0, 1'b1, f_fetch(1'b1), "brill_fetch");
    step(1'b0, 1'b0, f_decode(), "brill_decode");
    step(1'b0, 1'b0, ev(4'd12, 6'b0, 2'b00, 2'b10, 2'b00, SUB, 1'b0), "brill_exec");
    step(1'b0, 1'b0, f_trap(), "brill_trap");
    do_reset();
    instruction = 32'h00000000;
    step(1'b0, 1'b1, f_fetch(1'b1), "ill_fetch");
    step(1'b0, 1'b0, f_decode(), "ill_decode");
    step(1'b0, 1'b0, f_trap(), "ill_trap");
    step(1'b0, 1'b1, f_trap(), "ill_sticky");

    // u_dut2: bltu traps without unsigned-branch support
    do_reset();
    instruction = 32'h0020E463;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, f_fetch(1'b1), "bltu2_fetch");
    step(1'b1, 1'b0, f_decode(), "bltu2_decode");
    step(1'b1, 1'b0, ev(4'd12, 6'b0, 2'b00, 2'b10, 2'b00, SUB, 1'b0), "bltu2_exec");
    step(1'b1, 1'b0, f_trap(), "bltu2_trap");

    // u_dut2: FETCH timeout after four wait cycles, then reset clears trap
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, f_fetch(1'b0), "to_wait");
    step(1'b1, 1'b0, f_trap(), "to_trap");
    step(1'b1, 1'b1, f_trap(), "to_sticky");
    do_reset();

    // u_dut2: mem_ready on the last wait cycle wins over the timeout
    instruction = 32'h00500093;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, f_fetch(1'b0), "win_wait");
    step(1'b1, 1'b1, f_fetch(1'b1), "win_fetch");
    step(1'b1, 1'b0, f_decode(), "win_decode");
    step(1'b1, 1'b0, ev(4'd7, 6'b0, 2'b00, 2'b10, 2'b01, ADD, 1'b0), "win_exec");

    // drain: the monitor must have consumed every expectation
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
- Multicycle RV32I control FSM, second generation. Drives the shared-memory multicycle datapath: PC, OldPC, IR, Data and ALUOut registers, and the register file.
- Adds over the previous controller: memory ready handshake with wait states, a parametrised memory timeout, all six branch conditions, LUI, a two-step JALR, a sticky trap on illegal opcodes, and an integrated ALU control decoder.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready in any memory state. 0 disables the timeout.
- BR_UNSIGNED_EN, 1: 1 = bltu/bgeu supported. 0 = funct3 110/111 trap.
- STATE_W, 4: width of the state debug output.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- instruction, input, 32: IR contents.
- zero / negative / overflow / carry, input, 1 each: ALU flags from the current-cycle ALU result. carry=1 means no borrow on subtract.
- mem_ready, input, 1: memory completes the access this cycle.
- mem_req, output, 1: memory access request.
- AdrSrc, output, 1: 0 = PC, 1 = ALUOut.
- MemWrite, output, 1: memory write enable.
- IRWrite, output, 1: load IR and OldPC.
- pc_write, output, 1: load PC from the result bus.
- RegWrite, output, 1: register file write.
- ResultSrc, output, 2: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUSrca, output, 2: 00 = PC, 01 = OldPC, 10 = rs1 reg, 11 = zero.
- ALUSrcb, output, 2: 00 = rs2 reg, 01 = imm, 10 = constant 4.
- ALUControl, output, 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- trap, output, 1: sticky fault flag.
- state, output, STATE_W: present-state encoding, for debug.

Behaviour:
- Clocking: single clock domain. State and counters update on rising clk; outputs are combinational from state, opcode and flags.
- Reset: ps = FETCH, wait counter = 0, trap = 0. While reset is high, mem_req, MemWrite, IRWrite, pc_write and RegWrite are forced 0. Reset mid-access abandons the access with no write.
- Output defaults: all strobes 0; selects 00.

State encoding (value on the state output):
- FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, JAL 9, JALR_A 10, JALR_PC 11, BRANCH 12, LUI 13, TRAP 14.

State actions and transitions:
- FETCH: mem_req=1, AdrSrc=0, ALU = PC+4 (a=00, b=10, ADD), ResultSrc=10.
  - While mem_ready=0: hold in FETCH.
  - On mem_ready=1, same cycle: IRWrite=1, pc_write=1, go to DECODE.
- DECODE: ALU = OldPC+imm (ALUOut captures it). Next state by opcode:
  - 0000011 / 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100111 -> JALR_A
  - 1100011 -> BRANCH
  - 0010111 (AUIPC) -> ALU_WB
  - 0110111 -> LUI
  - any other opcode -> TRAP
- MEM_ADDR: ALU = rs1+imm. LOAD -> MEM_READ, STORE -> MEM_WRITE.
- MEM_READ: mem_req=1, AdrSrc=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1, go to FETCH.
- MEM_WRITE: mem_req=1, MemWrite=1, AdrSrc=1, held throughout. On mem_ready go to FETCH.
- EXEC_R: a=10, b=00. ALUControl per funct3/funct7[5]; SUB/SRA when funct7[5]=1. Go to ALU_WB.
- EXEC_I: a=10, b=01. Same decode, except SUB is never used; SRAI when funct7[5]=1. Go to ALU_WB.
- LUI: a=11, b=01, ADD. Go to ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1, go to FETCH.
- JAL: ResultSrc=00, pc_write=1; ALU = OldPC+4. Go to ALU_WB.
- JALR_A: ALU = rs1+imm. Go to JALR_PC.
  - JALR_PC: ResultSrc=00, pc_write=1, ALU = OldPC+4. Go to ALU_WB.
  - Bit 0 clearing of the target is done by the datapath.
- BRANCH: a=10, b=00, SUB, ResultSrc=00. pc_write=1 iff the condition holds, then go to FETCH:
  - beq: zero
  - bne: !zero
  - blt: negative^overflow
  - bge: !(negative^overflow)
  - bltu: !carry
  - bgeu: carry
  - funct3 010/011 -> TRAP. 110/111 -> TRAP when BR_UNSIGNED_EN=0.
- TRAP: all strobes 0, trap=1. Remains in TRAP until reset.

Memory timeout (MEM_TIMEOUT>0):
- Counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments on each cycle with mem_req=1 and mem_ready=0.
- If the counter reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP next cycle with no IRWrite, pc_write or register write.
- mem_ready on that same cycle wins over the timeout.
- Counter width is clog2(MEM_TIMEOUT+1).

Test Plan:
- addi x1,x0,5 with mem_ready tied high -> state sequence 0,1,7,8,0. RegWrite high exactly in ALU_WB; pc_write pulses once in FETCH.
- lw with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles, mem_req=1 throughout, then MEM_WB RegWrite=1 with ResultSrc=01.
- bltu, carry=0 -> pc_write=1 in BRANCH. Same with BR_UNSIGNED_EN=0 -> TRAP, trap=1. blt with negative=1, overflow=1 -> pc_write=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, IRWrite never asserted. Assert reset -> state=0, trap=0.
- jalr -> states 10, 11, 8. pc_write only in 11; RegWrite only in 8. lui -> states 1, 13, 8 with ALUSrca=11.
- Opcode 0000000 -> TRAP from DECODE. Reset asserted mid-MEM_WRITE -> MemWrite drops the same cycle and state returns to FETCH.
